// File: rtl/cacheline_adapter.sv
// Cache-line to memory-burst adapter: splits a 256-bit line transaction into
// 64-bit beats for the memory bus and reassembles read beats into a line.
module cacheline_adapter #(
   parameter int s_line  = 256,
   parameter int s_burst = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [s_line-1:0]  line_i,
   output logic [s_line-1:0]  line_o,
   input  logic [31:0]        address_i,
   input  logic               read_i,
   input  logic               write_i,
   output logic               resp_o,
   input  logic [s_burst-1:0] burst_i,
   output logic [s_burst-1:0] burst_o,
   output logic [31:0]        address_o,
   output logic               read_o,
   output logic               write_o,
   input  logic               resp_i
);

   localparam int num_beats = s_line / s_burst;
   localparam int s_beat    = $clog2(num_beats);
   localparam logic [31:0]       line_mask = ~32'(s_line / 8 - 1);
   localparam logic [s_beat-1:0] last_cnt  = s_beat'(num_beats - 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t            state, state_next;
   logic [s_beat-1:0] cnt;
   logic [s_line-1:0] line_buf;
   logic [31:0]       addr_q;
   logic              load_wr, load_rd, beat_en;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: every output of this block gets a default first so no path leaves
   // a signal unassigned, which would infer a latch.
   always_comb begin
      state_next = state;
      load_wr    = 1'b0;
      load_rd    = 1'b0;
      beat_en    = 1'b0;
      read_o     = 1'b0;
      write_o    = 1'b0;
      resp_o     = 1'b0;
      unique case (state)
         IDLE: begin
            // A simultaneous read and write is serviced as a write.
            if (write_i) begin
               load_wr    = 1'b1;
               state_next = WRITE;
            end else if (read_i) begin
               load_rd    = 1'b1;
               state_next = READ;
            end
         end
         READ: begin
            read_o = 1'b1;
            if (resp_i) begin
               beat_en = 1'b1;
               if (cnt == last_cnt) state_next = DONE;
            end
         end
         WRITE: begin
            write_o = 1'b1;
            if (resp_i) begin
               beat_en = 1'b1;
               if (cnt == last_cnt) state_next = DONE;
            end
         end
         DONE: begin
            resp_o     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: the line buffer is a plain register, not RAM, so it is reset; a
   // reset mid-burst must discard any partially assembled line.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         line_buf <= '0;
         addr_q   <= '0;
      end else if (load_wr) begin
         cnt      <= '0;
         line_buf <= line_i;
         addr_q   <= address_i & line_mask;
      end else if (load_rd) begin
         cnt      <= '0;
         addr_q   <= address_i & line_mask;
      end else if (beat_en) begin
         // Counter wraps to zero on the final beat.
         cnt <= cnt + 1'b1;
         if (read_o) line_buf[s_burst*cnt +: s_burst] <= burst_i;
      end
   end

   assign line_o    = line_buf;
   assign address_o = addr_q;
   assign burst_o   = line_buf[s_burst*cnt +: s_burst];

endmodule

// File: tb/tb_cacheline_adapter.sv
// Randomized bench for cacheline_adapter: a cache-side driver plus a burst
// memory responder, checked against a line-level transaction model.
module tb_cacheline_adapter;

   logic         clk = 1'b0;
   logic         rst;
   logic [255:0] line_i, line_o;
   logic [31:0]  address_i, address_o;
   logic         read_i, write_i, resp_o;
   logic [63:0]  burst_i, burst_o;
   logic         read_o, write_o, resp_i;

   int total = 0;
   int bad   = 0;

   // Model: what the adapter should present while idle.
   logic [255:0] last_line;
   logic [31:0]  last_addr;
   bit           resp_pat[$];

   cacheline_adapter dut (
      .clk(clk), .rst(rst),
      .line_i(line_i), .line_o(line_o),
      .address_i(address_i),
      .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
      .burst_i(burst_i), .burst_o(burst_o),
      .address_o(address_o),
      .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_read_o"}, read_o, 1'b0);
      check({tag, "_write_o"}, write_o, 1'b0);
      check({tag, "_resp_o"}, resp_o, 1'b0);
      check({tag, "_line_o"}, line_o, last_line);
      check({tag, "_addr_o"}, address_o, last_addr);
   endtask

   // One full cache transaction. Called and returns just after a rising edge.
   task automatic txn(input bit wr, input bit rd, input logic [31:0] addr,
                      input logic [255:0] wline, input logic [255:0] rline,
                      input int stall_pct);
      logic [31:0] exp_addr;
      bit          do_wr;
      bit          r;
      int          k;
      int          cyc;
      exp_addr = {addr[31:5], 5'b0};
      do_wr    = wr;
      k        = 0;
      cyc      = 0;
      read_i    = rd;
      write_i   = wr;
      address_i = addr;
      line_i    = wline;
      @(negedge clk);
      check_idle("req_cycle");
      @(posedge clk); #1;
      // Request stays asserted; captured operands must no longer matter.
      address_i = $urandom;
      line_i    = rand_line();
      while (k < 4 && cyc < 200) begin
         @(negedge clk);
         check("busy_read_o", read_o, !do_wr);
         check("busy_write_o", write_o, do_wr);
         check("busy_resp_o", resp_o, 1'b0);
         check("busy_addr_o", address_o, exp_addr);
         if (do_wr) check("burst_o", burst_o, wline[64*k +: 64]);
         if (resp_pat.size() > 0) r = resp_pat.pop_front();
         else                     r = ($urandom_range(99) >= stall_pct);
         resp_i  = r;
         burst_i = r ? rline[64*k +: 64] : 64'($urandom);
         @(posedge clk); #1;
         if (r) k++;
         cyc++;
         resp_i  = 1'b0;
         burst_i = 64'($urandom);
      end
      if (k < 4) check("burst_timeout", 1'b0, 1'b1);
      @(negedge clk);
      check("done_resp_o", resp_o, 1'b1);
      check("done_read_o", read_o, 1'b0);
      check("done_write_o", write_o, 1'b0);
      last_line = do_wr ? wline : rline;
      last_addr = exp_addr;
      if (!do_wr) check("done_line_o", line_o, rline);
      @(posedge clk); #1;
      read_i  = 1'b0;
      write_i = 1'b0;
   endtask

   task automatic reset_mid_read(input logic [31:0] addr);
      read_i    = 1'b1;
      address_i = addr;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         resp_i  = 1'b1;
         burst_i = {2{$urandom}};
         @(posedge clk); #1;
      end
      resp_i = 1'b0;
      read_i = 1'b0;
      rst    = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      last_line = '0;
      last_addr = '0;
      check_idle("after_rst");
      check("after_rst_burst_o", burst_o, 64'h0);
      @(posedge clk); #1;
   endtask

   task automatic spurious_idle();
      for (int i = 0; i < 4; i++) begin
         resp_i  = 1'b1;
         burst_i = {$urandom, $urandom};
         @(negedge clk);
         check_idle("spurious");
         check("spurious_burst_o", burst_o, last_line[63:0]);
         @(posedge clk); #1;
      end
      resp_i = 1'b0;
      @(negedge clk);
      check_idle("spurious_after");
      @(posedge clk); #1;
   endtask

   initial begin
      logic [255:0] l;
      rst       = 1'b1;
      line_i    = '0;
      address_i = '0;
      read_i    = 1'b0;
      write_i   = 1'b0;
      burst_i   = '0;
      resp_i    = 1'b0;
      last_line = '0;
      last_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check_idle("reset");
      check("reset_burst_o", burst_o, 64'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Read without stalls.
      l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
      txn(1'b0, 1'b1, 32'h1234_5678, rand_line(), l, 0);
      check("read_addr_value", last_addr, 32'h1234_5660);

      // Write without stalls.
      txn(1'b1, 1'b0, 32'h0000_00A0, rand_line(), rand_line(), 0);

      // Stalled read with a fixed response pattern.
      resp_pat = '{1, 0, 0, 1, 1, 0, 1};
      txn(1'b0, 1'b1, 32'hDEAD_BEEF, rand_line(), rand_line(), 0);

      reset_mid_read(32'h0000_1040);
      txn(1'b0, 1'b1, 32'h0000_1040, rand_line(), rand_line(), 0);

      // Back-to-back write then read.
      txn(1'b1, 1'b0, 32'h0000_2000, rand_line(), rand_line(), 20);
      txn(1'b0, 1'b1, 32'h0000_2000, rand_line(), rand_line(), 20);

      spurious_idle();

      // Conflicting request is serviced as a write.
      txn(1'b1, 1'b1, 32'h0BAD_F00D, rand_line(), rand_line(), 0);

      for (int i = 0; i < 25; i++) begin
         txn(($urandom_range(1) == 1), ($urandom_range(1) == 1) || 1'b1, $urandom,
             rand_line(), rand_line(), $urandom_range(60));
         if ($urandom_range(3) == 0) spurious_idle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
